// File: rtl/reg_dump_reader.sv
// Debug-port register dump sequencer: walks first_addr..last_addr (with wrap) and streams each
// register's value over valid/ready. Define REG_DUMP_CHECKSUM_EN to append a modular checksum word.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  input  logic [DATA_W-1:0] final_res,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] SUM   = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  always_comb begin
    state_d     = state_q;
    reg_addr_d  = reg_addr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          reg_addr_d = first_addr;
          last_d     = last_addr;
          state_d    = FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d      = '0;
`endif
        end
      end
      FETCH: begin
        out_data_d  = final_res;
        out_idx_d   = reg_addr_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (reg_addr_q == last_q);
`endif
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_d       = acc_q + out_data_q;
`endif
          if (reg_addr_q == last_q) begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
`endif
          end else begin
            reg_addr_d = reg_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d    = FETCH;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      // First cycle loads the checksum word (mirrors FETCH), then waits for the handshake.
      SUM: begin
        if (!out_valid_q) begin
          out_data_d  = acc_q;
          out_idx_d   = last_q;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides any handshake completing in the same cycle.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      reg_addr_q  <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      reg_addr_q  <= reg_addr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign reg_addr  = reg_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a register-file model feeds final_res, expected words
// are queued at start and popped as the stream transfers them.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic        abort = 1'b0;
  logic [15:0] final_res;
  logic [4:0]  reg_addr;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] regs [32];
  exp_t        sb_q [$];
  int          n_err = 0;
  int          n_checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;

  reg_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .abort(abort), .final_res(final_res), .reg_addr(reg_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign final_res = regs[reg_addr];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // A transfer happens at the next rising edge when valid & ready and no abort is pending.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !abort) begin
      $display("word idx=%0d data=0x%04h last=%0b", out_idx, out_data, out_last);
      check("sb_word_expected", 32'(sb_q.size() != 0), 32'(1));
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("word_idx", 32'(out_idx), 32'(e.idx));
        check("word_data", 32'(out_data), 32'(e.data));
        check("word_last", 32'(out_last), 32'(e.last));
      end
    end
    if (done) done_cnt++;
  end

  function automatic int push_exp(input logic [4:0] f, input logic [4:0] l);
    logic [4:0]  a;
    logic [4:0]  d;
    logic [15:0] sum;
    exp_t        e;
    int          n;
    d   = l - f;
    n   = int'(d) + 1;
    a   = f;
    sum = '0;
    for (int k = 0; k < n; k++) begin
      e.idx  = a;
      e.data = regs[a];
`ifdef REG_DUMP_CHECKSUM_EN
      e.last = 1'b0;
`else
      e.last = (k == n - 1);
`endif
      sum = sum + regs[a];
      sb_q.push_back(e);
      a = a + 5'd1;
    end
`ifdef REG_DUMP_CHECKSUM_EN
    e.idx  = l;
    e.data = sum;
    e.last = 1'b1;
    sb_q.push_back(e);
    n = n + 1;
`endif
    return n;
  endfunction

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l, output int t0, output int nw);
    nw = push_exp(f, l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    t0         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat < 0 skips the latency comparison (used when the stream is stalled).
  task automatic wait_done(input string tag, input int t0, input int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    if (seen && lat >= 0) check({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
    check({tag, "_all_words_sent"}, 32'(sb_q.size()), 32'(0));
    sb_q.delete();
  endtask

  task automatic wait_idx_valid(input logic [4:0] idx);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (out_valid && out_idx == idx) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("idx_became_valid", 32'(hit), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_data"}, 32'(out_data), 32'(0));
    check({tag, "_out_idx"}, 32'(out_idx), 32'(0));
    check({tag, "_out_last"}, 32'(out_last), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
  endtask

  initial begin
    int t0;
    int nw;
    int dc;
    bit hit;
    for (int i = 0; i < 32; i++) regs[i] = 16'h1000 + 16'(i);

    #3 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Basic dump 3..5 with ready tied high.
    start_dump(5'd3, 5'd5, t0, nw);
    wait_done("basic", t0, 2 * nw + 1);
    @(negedge clk);
    check("basic_busy_after_done", 32'(busy), 32'(0));
    check("basic_done_one_cycle", 32'(done), 32'(0));

    // Wrap-around 30..1.
    start_dump(5'd30, 5'd1, t0, nw);
    check("wrap_word_count", 32'(sb_q.size()), 32'(nw));
    wait_done("wrap", t0, 2 * nw + 1);
    check("wrap_reg_addr_end", 32'(reg_addr), 32'(1));

    // Backpressure: hold ready low while idx 4 is presented.
    start_dump(5'd3, 5'd6, t0, nw);
    wait_idx_valid(5'd4);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_idx", 32'(out_idx), 32'(4));
      check("bp_data", 32'(out_data), 32'h1004);
      check("bp_last", 32'(out_last), 32'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp", t0, -1);

    // Abort while idx 4 is valid and ready is high: abort wins.
    start_dump(5'd3, 5'd6, t0, nw);
    wait_idx_valid(5'd4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb_q.delete();
    check("abort_valid", 32'(out_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_last", 32'(out_last), 32'(0));
    dc = done_cnt;
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    start_dump(5'd7, 5'd7, t0, nw);
    wait_done("single", t0, 2 * nw + 1);

    // Start pulses while busy must be ignored.
    start_dump(5'd8, 5'd10, t0, nw);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      first_addr = 5'd20;
      last_addr  = 5'd25;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done("busy_start", t0, 2 * nw + 1);

    // Asynchronous reset during FETCH of idx 10.
    start_dump(5'd9, 5'd12, t0, nw);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (busy && !out_valid && reg_addr == 5'd10) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("rst_fetch10_reached", 32'(hit), 32'(1));
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    sb_q.delete();
    @(negedge clk) rst = 1'b1;

    // Dump 0..2 (with checksum word when the feature is built in).
    start_dump(5'd0, 5'd2, t0, nw);
    wait_done("sum", t0, 2 * nw + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
